// File: rtl/led_fader.sv
// led_fader: turns the on/off LED pattern from the PIO export into PWM
// fade-in / fade-out per LED. Each channel ramps its brightness level by one
// step per prescaler tick toward full-on or full-off. With enable low the
// pattern passes straight through (bypass). busy flags any channel still fading.
module led_fader #(
    parameter int NUM_LEDS  = 8,
    parameter int PWM_BITS  = 8,
    parameter int MAX_LEVEL = 255,
    parameter int STEP_DIV  = 50000
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_LEDS-1:0] leds_in,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                busy
);

    localparam int                  PRESC_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX    = PWM_BITS'(MAX_LEVEL);
    localparam logic [PWM_BITS-1:0] LVL_ZERO   = PWM_BITS'(0);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'(MAX_LEVEL - 1);

    // Channel state travels alongside its level: OFF/ON are the settled
    // endpoints, RISING/FALLING are the fade directions.
    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_RISING  = 2'd1,
        S_ON      = 2'd2,
        S_FALLING = 2'd3
    } fade_state_t;

    // Brightness moves one step up, saturating at full brightness.
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] lvl);
        return (lvl == LVL_MAX) ? LVL_MAX : lvl + PWM_BITS'(1);
    endfunction

    // Brightness moves one step down, saturating at zero.
    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] lvl);
        return (lvl == LVL_ZERO) ? LVL_ZERO : lvl - PWM_BITS'(1);
    endfunction

    // Full-on or full-off level requested by one synchronised pattern bit.
    function automatic logic [PWM_BITS-1:0] target_of(input logic on);
        return on ? LVL_MAX : LVL_ZERO;
    endfunction

    logic [NUM_LEDS-1:0] tgt_p0;
    logic [NUM_LEDS-1:0] tgt;
    logic                en_p0;
    logic                en_s;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic                tick;

    fade_state_t         state     [NUM_LEDS];
    fade_state_t         state_nxt [NUM_LEDS];
    logic [PWM_BITS-1:0] level     [NUM_LEDS];
    logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
    logic                mismatch;

    // Two-flop synchronisers for the pattern and the enable from software.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tgt_p0 <= '0;
            tgt    <= '0;
            en_p0  <= 1'b0;
            en_s   <= 1'b0;
        end else begin
            tgt_p0 <= leds_in;
            tgt    <= tgt_p0;
            en_p0  <= enable;
            en_s   <= en_p0;
        end
    end

    // Free-running PWM counter, period MAX_LEVEL so level MAX is always on.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Prescaler that paces the brightness steps.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    assign tick = (presc == PRESC_LAST);

    // Per-channel fade FSM: pick direction from the current target, step on tick.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            state_nxt[i] = state[i];
            level_nxt[i] = level[i];
            if (!en_s) begin
                // Bypass snaps straight to the endpoint so re-enabling shows no fade.
                level_nxt[i] = target_of(tgt[i]);
                state_nxt[i] = tgt[i] ? S_ON : S_OFF;
            end else begin
                case (state[i])
                    S_OFF: begin
                        if (tgt[i]) begin
                            state_nxt[i] = S_RISING;
                            if (tick) level_nxt[i] = sat_inc(level[i]);
                        end
                    end
                    S_ON: begin
                        if (!tgt[i]) begin
                            state_nxt[i] = S_FALLING;
                            if (tick) level_nxt[i] = sat_dec(level[i]);
                        end
                    end
                    S_RISING: begin
                        if (tgt[i]) begin
                            if (tick) level_nxt[i] = sat_inc(level[i]);
                        end else begin
                            // Reversal resumes from the current level, no jump.
                            state_nxt[i] = S_FALLING;
                            if (tick) level_nxt[i] = sat_dec(level[i]);
                        end
                    end
                    S_FALLING: begin
                        if (!tgt[i]) begin
                            if (tick) level_nxt[i] = sat_dec(level[i]);
                        end else begin
                            state_nxt[i] = S_RISING;
                            if (tick) level_nxt[i] = sat_inc(level[i]);
                        end
                    end
                    default: begin
                        state_nxt[i] = S_OFF;
                    end
                endcase
                // A fade that lands on its endpoint settles there.
                if (tgt[i] && (level_nxt[i] == LVL_MAX)) begin
                    state_nxt[i] = S_ON;
                end else if (!tgt[i] && (level_nxt[i] == LVL_ZERO)) begin
                    state_nxt[i] = S_OFF;
                end
            end
        end
    end

    // Per-channel state and level registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                state[i] <= S_OFF;
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                state[i] <= state_nxt[i];
                level[i] <= level_nxt[i];
            end
        end
    end

    // Any channel whose level has not yet reached its target.
    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mismatch = mismatch | (level[i] != target_of(tgt[i]));
        end
    end

    // Registered LED drive: PWM compare in fade mode, raw pattern in bypass.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            leds_out <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                leds_out[i] <= en_s ? (level[i] > pwm_cnt) : tgt[i];
            end
        end
    end

    // busy ignores the one-cycle bypass catch-up, which is never a visible fade.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            busy <= 1'b0;
        end else begin
            busy <= en_s & mismatch;
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: fade ramp, duty cycle, reversal, bypass,
// asynchronous reset mid-fade and channel independence.
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] leds_in;
    logic       enable;
    logic [7:0] leds_out;
    logic       busy;

    logic       rst_slow;
    logic [7:0] leds_in_slow;
    logic       enable_slow;
    logic [7:0] leds_out_slow;
    logic       busy_slow;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    led_fader #(.NUM_LEDS(8), .PWM_BITS(8), .MAX_LEVEL(255), .STEP_DIV(4)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .leds_in     (leds_in),
        .enable      (enable),
        .leds_out    (leds_out),
        .busy        (busy)
    );

    led_fader #(.NUM_LEDS(8), .PWM_BITS(8), .MAX_LEVEL(255), .STEP_DIV(300)) u_slow (
        .clk_clk     (clk),
        .reset_reset (rst_slow),
        .leds_in     (leds_in_slow),
        .enable      (enable_slow),
        .leds_out    (leds_out_slow),
        .busy        (busy_slow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; sample point is 1ns after each edge.
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic go_to(input int k);
        while (edge_n < k) adv(1);
    endtask

    // Reset with the given inputs applied; the next posedge after return is edge 1.
    task automatic start(input logic [7:0] pat, input logic en);
        rst     = 1'b1;
        leds_in = pat;
        enable  = en;
        adv(2);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        logic [7:0] hi_or;
        logic       busy_or;
        int         cnt;
        int         bad;
        logic [7:0] prev;

        rst          = 1'b1;
        rst_slow     = 1'b1;
        leds_in      = 8'h00;
        enable       = 1'b1;
        leds_in_slow = 8'h01;
        enable_slow  = 1'b1;
        adv(2);
        check("reset_leds_out", leds_out, 8'h00);
        check("reset_busy", busy, 1'b0);

        // Full fade-in of LED0
        start(8'h01, 1'b1);
        hi_or = 8'h00;
        adv(2);
        check("t1_busy_e2", busy, 1'b0);
        adv(1);
        check("t1_busy_e3", busy, 1'b1);
        while (edge_n < 1020) begin
            adv(1);
            hi_or |= {leds_out[7:1], 1'b0};
        end
        check("t1_busy_e1020", busy, 1'b1);
        adv(1);
        check("t1_busy_e1021", busy, 1'b0);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (leds_out[0]) cnt++;
            hi_or |= {leds_out[7:1], 1'b0};
            adv(1);
        end
        check("t1_led0_const_on", cnt, 300);
        check("t1_upper_leds_off", hi_or, 8'h00);

        // Reversal at level 100
        start(8'h01, 1'b1);
        go_to(398);
        leds_in = 8'h00;
        go_to(400);
        check("t3_level_peak", dut.level[0], 8'd100);
        bad  = 0;
        prev = dut.level[0];
        while (edge_n < 800) begin
            adv(1);
            if (dut.level[0] > prev || dut.level[0] > 8'd100) bad++;
            prev = dut.level[0];
            if (edge_n == 600) check("t3_level_e600", dut.level[0], 8'd50);
            if (edge_n == 799) check("t3_level_e799", dut.level[0], 8'd1);
        end
        check("t3_monotonic", bad, 0);
        check("t3_level_e800", dut.level[0], 8'd0);
        check("t3_busy_e800", busy, 1'b1);
        adv(1);
        check("t3_busy_e801", busy, 1'b0);

        // Bypass, 3-cycle latency, then enable with no visible fade
        start(8'h00, 1'b0);
        busy_or = 1'b0;
        go_to(5);
        leds_in = 8'hA5;
        adv(2);
        busy_or |= busy;
        check("t4_a5_e7", leds_out, 8'h00);
        adv(1);
        busy_or |= busy;
        check("t4_a5_e8", leds_out, 8'hA5);
        go_to(10);
        leds_in = 8'h5A;
        adv(2);
        busy_or |= busy;
        check("t4_5a_e12", leds_out, 8'hA5);
        adv(1);
        busy_or |= busy;
        check("t4_5a_e13", leds_out, 8'h5A);
        go_to(20);
        enable = 1'b1;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            adv(1);
            busy_or |= busy;
            if (leds_out !== 8'h5A) bad++;
        end
        check("t4_enable_no_fade", bad, 0);
        check("t4_busy_never", busy_or, 1'b0);

        // Asynchronous reset mid-fade
        start(8'hFF, 1'b1);
        go_to(240);
        check("t5_level_e240", dut.level[3], 8'd60);
        check("t5_busy_e240", busy, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_leds_out", leds_out, 8'h00);
        check("t5_async_busy", busy, 1'b0);
        check("t5_async_level", dut.level[3], 8'd0);
        start(8'hFF, 1'b1);
        adv(3);
        check("t5_restart_level_e3", dut.level[5], 8'd0);
        check("t5_restart_out_e3", leds_out, 8'h00);
        check("t5_restart_busy_e3", busy, 1'b1);
        adv(1);
        check("t5_restart_level_e4", dut.level[5], 8'd1);

        // Independence of LED0 and LED7
        start(8'h81, 1'b1);
        hi_or = 8'h00;
        go_to(198);
        leds_in = 8'h80;
        while (edge_n < 1020) begin
            adv(1);
            hi_or |= {1'b0, leds_out[6:1], 1'b0};
            if (edge_n == 200) begin
                check("t6_led0_e200", dut.level[0], 8'd50);
                check("t6_led7_e200", dut.level[7], 8'd50);
            end
            if (edge_n == 300) begin
                check("t6_led0_e300", dut.level[0], 8'd25);
                check("t6_led7_e300", dut.level[7], 8'd75);
            end
            if (edge_n == 400) begin
                check("t6_led0_e400", dut.level[0], 8'd0);
                check("t6_led7_e400", dut.level[7], 8'd100);
            end
        end
        check("t6_busy_e1020", busy, 1'b1);
        adv(1);
        check("t6_busy_e1021", busy, 1'b0);
        check("t6_leds_out_e1021", leds_out, 8'h80);
        check("t6_mid_leds_off", hi_or, 8'h00);

        // Duty cycle on the slow instance: windows inside constant-level spans
        @(posedge clk);
        #1;
        rst_slow = 1'b0;
        edge_n   = 0;
        cnt      = 0;
        bad      = 0;
        while (edge_n < 38664) begin
            adv(1);
            if (edge_n >= 320 && edge_n <= 574 && leds_out_slow[0]) cnt++;
            if (edge_n >= 38410 && leds_out_slow[0]) bad++;
            if (edge_n == 1000) check("t2_busy_slow", busy_slow, 1'b1);
        end
        check("t2_duty_level1", cnt, 1);
        check("t2_duty_level128", bad, 128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Sits directly downstream of the NIOS II system's 8-bit LED PIO export and drives the board LED pins.
- Turns each on/off bit from software into a soft PWM fade-in or fade-out, so LED pattern changes look smooth instead of abrupt.
- Each LED has its own brightness level, ramped one step per prescaler tick.
- Includes a bypass mode and a busy flag.

Parameters:
NUM_LEDS, 8, number of LED channels (matches the PIO export width)
PWM_BITS, 8, brightness level / PWM counter width
MAX_LEVEL, 255, full-brightness level; must be 2**PWM_BITS-1
STEP_DIV, 50000, clk_clk cycles per brightness step (minimum 2)

Ports:
clk_clk  in  1  system clock, same domain as the NIOS II system
reset_reset  in  1  asynchronous, active-high reset
leds_in  in  NUM_LEDS  target pattern from the PIO export; 1 = on
enable  in  1  1 = fade mode, 0 = bypass (immediate on/off)
leds_out  out  NUM_LEDS  PWM-modulated LED drive, registered
busy  out  1  1 while any channel level differs from its target

Behaviour:
- Reset (asynchronous, active-high) clears every register to 0: sync stages, levels, pwm_cnt, prescaler, leds_out, busy. The effect is immediate, including mid-fade.
- Input sync:
  - leds_in and enable each pass through two flops, giving tgt[i] and en_s.
  - A change on an input is visible internally 2 cycles later.
- Per-channel target: target_level[i] = tgt[i] ? MAX_LEVEL : 0.
- PWM counter:
  - pwm_cnt counts 0..MAX_LEVEL-1 and wraps to 0, so the period is MAX_LEVEL cycles (255).
  - It runs free; it is not reset by input changes.
- Prescaler:
  - presc counts 0..STEP_DIV-1 and wraps.
  - tick is 1 for exactly the one cycle where presc == STEP_DIV-1.
- Per-channel FSM, 4 states, with state encoded together with level[i]:
  - OFF (level 0, tgt 0)
  - RISING
  - ON (level MAX, tgt 1)
  - FALLING
  - OFF -> RISING when tgt=1. ON -> FALLING when tgt=0.
  - RISING: on tick, level+1; on reaching MAX -> ON.
  - FALLING: on tick, level-1; on reaching 0 -> OFF.
  - RISING <-> FALLING on a tgt change mid-fade. Reversal continues from the current level: no jump, no extra step.
  - Level saturates at 0 and MAX_LEVEL; it never wraps.
- Fade mode (en_s=1):
  - leds_out[i] <= (level[i] > pwm_cnt): 1 cycle of register latency.
  - Level 0 gives constant 0. MAX_LEVEL gives constant 1. Level L gives exactly L high cycles per 255-cycle period.
- Bypass (en_s=0):
  - level[i] <= target_level[i] every cycle.
  - leds_out[i] <= tgt[i].
  - Total latency from leds_in to leds_out is 3 cycles.
  - Switching enable 0->1 starts from the settled levels, so there is no visible fade.
- busy:
  - Registered OR over channels of (level[i] != target_level[i]).
  - Asserts 1 cycle after the level/target mismatch appears.
- Simultaneous events:
  - A tgt change arriving on a tick cycle uses the new direction for that same tick.
  - Channels are fully independent of each other.
- Full fade time is MAX_LEVEL*STEP_DIV cycles. First step occurs within STEP_DIV cycles after sync.

Test Plan:
1. STEP_DIV=4, enable=1, leds_in 0x00->0x01 at cycle 0 -> busy=1 by cycle 4; level[0] reaches 255 after 255 ticks (~1020 cycles); then leds_out[0] constant 1, busy=0, leds_out[7:1]=0 throughout.
2. Duty check: with level[0] settled at 128 (leds_in=0x01, then enable=0 is not used; stop stepping by forcing STEP_DIV large after 128 ticks) -> over any 255-cycle window, leds_out[0] is high exactly 128 cycles.
3. Reversal: leds_in=0x01 for 100 ticks, then 0x00 -> level[0] decreases monotonically 100->0 over the next 100 ticks, never exceeds 100; busy drops 1 cycle after level 0.
4. Bypass: enable=0, leds_in=0xA5 -> leds_out=0xA5 exactly 3 cycles later, busy stays 0; then leds_in=0x5A -> leds_out=0x5A 3 cycles later.
5. Reset mid-fade: 0xFF fading at level ~60, assert reset_reset asynchronously between clock edges -> leds_out=0x00 and busy=0 immediately; after release with leds_in=0xFF, fade restarts from 0.
6. Independence: leds_in=0x81, then 0x80 after 50 ticks -> LED7 continues rising to 255 unaffected; LED0 falls 50->0; other LEDs remain 0.
